// File: rtl/voice_allocator.sv
// voice_allocator
// Two-voice note allocator with per-key synchronisation, debouncing and
// oldest-voice stealing. Held notes keep their channel while other keys
// change.
//
// Parameters:
//   SAMPLE_DIV  - clock cycles between debounce samples (>= 2)
//   DEB_SAMPLES - consecutive differing samples needed to accept a change (2..15)
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-low reset
//   keys       - raw key levels, bit k = key k, 1 = pressed, asynchronous
//   voice1     - key code on voice 1 (k+1 for key k, 0 = silent)
//   voice2     - key code on voice 2, same encoding
//   note_event - one-cycle pulse in the cycle after either voice changes
module voice_allocator #(
    parameter int SAMPLE_DIV  = 50000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] keys,
    output logic [5:0]  voice1,
    output logic [5:0]  voice2,
    output logic        note_event
);

    localparam int             CW      = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(SAMPLE_DIV - 1);
    localparam logic [3:0]     DC_MAX  = 4'(DEB_SAMPLES - 1);
    localparam logic [5:0]     IDX_MAX = 6'd47;

    logic [47:0]   ks1;
    logic [47:0]   ks;
    logic [47:0]   st;
    logic [47:0]   sn;
    logic [3:0]    dc [48];
    logic [CW-1:0] cnt;
    logic          strobe;
    logic [5:0]    idx;
    logic          old;
    logic [5:0]    prev1;
    logic [5:0]    prev2;
    logic          ev;
    logic          press;
    logic [5:0]    code;

    assign strobe = (cnt == CNT_MAX);
    assign ev     = (st[idx] != sn[idx]);
    assign press  = st[idx];
    assign code   = idx + 6'd1;

    // Two-flop synchroniser and sample-strobe divider
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ks1 <= '0;
            ks  <= '0;
            cnt <= '0;
        end else begin
            ks1 <= keys;
            ks  <= ks1;
            cnt <= strobe ? '0 : cnt + 1'b1;
        end
    end

    // Debounce: a key's stable level only follows the synchronised level
    // after DEB_SAMPLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= '0;
            for (int k = 0; k < 48; k++) dc[k] <= '0;
        end else if (strobe) begin
            for (int k = 0; k < 48; k++) begin
                if (ks[k] == st[k]) begin
                    dc[k] <= '0;
                end else if (dc[k] == DC_MAX) begin
                    st[k] <= ks[k];
                    dc[k] <= '0;
                end else begin
                    dc[k] <= dc[k] + 4'd1;
                end
            end
        end
    end

    // Scanner: one key per cycle; a key's seen bit catches up with its
    // stable bit when visited, so a flip-and-back between visits is absorbed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
            sn  <= '0;
        end else begin
            idx <= (idx == IDX_MAX) ? 6'd0 : idx + 6'd1;
            if (ev) sn[idx] <= st[idx];
        end
    end

    // Voice assignment. old = 0 means voice1 holds the older note.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            voice1 <= '0;
            voice2 <= '0;
            old    <= 1'b0;
        end else if (ev) begin
            if (press) begin
                if (voice1 == 6'd0) begin
                    voice1 <= code;
                    old    <= (voice2 != 6'd0);
                end else if (voice2 == 6'd0) begin
                    // voice1 is occupied, so it is the older one
                    voice2 <= code;
                    old    <= 1'b0;
                end else if (!old) begin
                    voice1 <= code;
                    old    <= 1'b1;
                end else begin
                    voice2 <= code;
                    old    <= 1'b0;
                end
            end else begin
                // A stolen key matches neither voice and is ignored here
                if (voice1 == code) voice1 <= 6'd0;
                if (voice2 == code) voice2 <= 6'd0;
            end
        end
    end

    // Change detector on the voice outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev1      <= '0;
            prev2      <= '0;
            note_event <= 1'b0;
        end else begin
            prev1      <= voice1;
            prev2      <= voice2;
            note_event <= (voice1 != prev1) || (voice2 != prev2);
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

    localparam int SD = 4;
    localparam int DS = 4;
    localparam int SETTLE = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [47:0] keys = '1;
    logic [5:0]  voice1;
    logic [5:0]  voice2;
    logic        note_event;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pulses = 0;
    int t_last = 0;
    int t_prev = 0;

    // Reference model: two voice slots, each remembering when it was filled
    int mv [2];
    int mt [2];
    int tstamp = 0;

    voice_allocator #(.SAMPLE_DIV(SD), .DEB_SAMPLES(DS)) dut (
        .clk(clk),
        .reset(reset),
        .keys(keys),
        .voice1(voice1),
        .voice2(voice2),
        .note_event(note_event)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (note_event) begin
            pulses <= pulses + 1;
            t_prev <= t_last;
            t_last <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic m_clear();
        mv[0] = 0; mv[1] = 0; mt[0] = 0; mt[1] = 0;
    endtask

    task automatic m_press(input int k);
        int slot;
        tstamp++;
        if (mv[0] == 0)      slot = 0;
        else if (mv[1] == 0) slot = 1;
        else                 slot = (mt[0] < mt[1]) ? 0 : 1;
        mv[slot] = k + 1;
        mt[slot] = tstamp;
    endtask

    task automatic m_release(input int k);
        for (int s = 0; s < 2; s++) if (mv[s] == k + 1) mv[s] = 0;
    endtask

    // Scan position at which keys held through reset release become stable:
    // 2 sync cycles, then the DS-th strobe, then one more cycle for st.
    function automatic int start_pos();
        int c;
        c = 2;
        while ((c % SD) != (SD - 1)) c++;
        c += SD * (DS - 1);
        return (c + 1) % 48;
    endfunction

    function automatic int scan_pos(input int k);
        return (k - start_pos() + 48) % 48;
    endfunction

    // Keys held through reset release are pressed in scan order
    task automatic m_from_reset(input logic [47:0] kv);
        int k;
        m_clear();
        for (int p = 0; p < 48; p++) begin
            k = (start_pos() + p) % 48;
            if (kv[k]) m_press(k);
        end
    endtask

    task automatic do_reset(input logic [47:0] kv, input string tag);
        @(negedge clk);
        reset = 1'b0;
        keys  = kv;
        #1;
        chk({tag, "_async_v1"}, voice1, 0);
        chk({tag, "_async_v2"}, voice2, 0);
        wait_cyc(5);
        chk({tag, "_hold_ev"}, note_event, 0);
        @(negedge clk);
        reset = 1'b1;
        m_from_reset(kv);
    endtask

    task automatic change(input int k, input logic val, input string tag);
        int b0, b1, p0, exp_p;
        b0 = mv[0]; b1 = mv[1];
        keys[k] = val;
        if (val) m_press(k); else m_release(k);
        exp_p = ((mv[0] != b0) || (mv[1] != b1)) ? 1 : 0;
        p0 = pulses;
        wait_cyc(SETTLE + $urandom_range(0, 7));
        chk({tag, "_v1"}, voice1, mv[0]);
        chk({tag, "_v2"}, voice2, mv[1]);
        chk({tag, "_pulses"}, pulses - p0, exp_p);
    endtask

    task automatic glitch(input int k, input int len, input string tag);
        int p0;
        p0 = pulses;
        keys[k] = 1'b1;
        wait_cyc(len);
        keys[k] = 1'b0;
        wait_cyc(SETTLE);
        chk({tag, "_v1"}, voice1, mv[0]);
        chk({tag, "_v2"}, voice2, mv[1]);
        chk({tag, "_pulses"}, pulses - p0, 0);
    endtask

    initial begin
        int p0, k, d;
        m_clear();

        // Reset with every key held
        wait_cyc(5);
        chk("rst_v1", voice1, 0);
        chk("rst_v2", voice2, 0);
        chk("rst_ev", note_event, 0);
        @(negedge clk);
        p0 = pulses;
        reset = 1'b1;
        m_from_reset('1);
        wait_cyc(2 + SD * DS + 48 + 1 + 10);
        chk("allkeys_v1", voice1, mv[0]);
        chk("allkeys_v2", voice2, mv[1]);
        chk("allkeys_pulses", pulses - p0, 48);
        p0 = pulses;
        wait_cyc(60);
        chk("allkeys_stable_v1", voice1, mv[0]);
        chk("allkeys_stable_v2", voice2, mv[1]);
        chk("allkeys_stable_pulses", pulses - p0, 0);

        // Reset mid-operation, keyboard idle afterwards
        do_reset('0, "midrst");
        wait_cyc(10);

        // Single note
        change(9, 1'b1, "single_press");
        chk("single_press_code", voice1, 10);
        change(9, 1'b0, "single_release");

        // Bounce rejection
        p0 = pulses;
        for (int i = 0; i < 12; i++) begin
            keys[20] = ~keys[20];
            wait_cyc(5);
        end
        keys[20] = 1'b0;
        wait_cyc(SETTLE);
        chk("bounce_v1", voice1, 0);
        chk("bounce_v2", voice2, 0);
        chk("bounce_pulses", pulses - p0, 0);

        // Allocation and steal
        change(3, 1'b1, "alloc_k3");
        change(7, 1'b1, "alloc_k7");
        change(30, 1'b1, "steal_k30");
        change(3, 1'b0, "rel_stolen_k3");
        change(7, 1'b0, "rel_k7");
        change(30, 1'b0, "rel_k30");

        // Free-slot reuse and age tracking
        change(4, 1'b1, "reuse_k4");
        change(11, 1'b1, "reuse_k11");
        change(4, 1'b0, "reuse_rel_k4");
        change(40, 1'b1, "reuse_k40");
        change(0, 1'b1, "reuse_k0_steal");
        chk("reuse_final_v2", voice2, 1);
        change(40, 1'b0, "reuse_rel_k40");
        change(11, 1'b0, "reuse_rel_k11");
        change(0, 1'b0, "reuse_rel_k0");

        // Randomised toggles and short glitches
        for (int i = 0; i < 36; i++) begin
            k = $urandom_range(0, 47);
            if ($urandom_range(0, 3) == 0 && !keys[k])
                glitch(k, $urandom_range(1, 10), $sformatf("rnd%0d_glitch_k%0d", i, k));
            else
                change(k, ~keys[k], $sformatf("rnd%0d_k%0d", i, k));
        end

        // Simultaneous press from reset
        do_reset('0, "simrst");
        wait_cyc(10);
        keys = '0;
        keys[2] = 1'b1;
        keys[45] = 1'b1;
        do_reset(keys, "sim");
        p0 = pulses;
        wait_cyc(2 + SD * DS + 48 + 1 + 10);
        chk("sim_v1", voice1, mv[0]);
        chk("sim_v2", voice2, mv[1]);
        chk("sim_pulses", pulses - p0, 2);
        d = scan_pos(45) - scan_pos(2);
        if (d < 0) d = -d;
        chk("sim_spacing", t_last - t_prev, d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
